// File: rtl/ucie_ctl_rx_path_if.sv
// ucie_ctl_rx_path_if: bundle of the RDI receive inputs and the FDI receive outputs
// for ucie_ctl_rx_path. The slave modport is the controller's view; master is the
// environment (PHY plus protocol layer) driving it.
// Optional macro UCIE_CTL_RX_PARITY_EN adds i_rdi_pl_parity and o_rx_parity_err.
interface ucie_ctl_rx_path_if #(
  parameter int D_SIZE = 64,
  parameter int P_SIZE = 3
);
  logic [3:0]        i_fdi_pl_state_sts;
  logic              i_rdi_pl_valid;
  logic [D_SIZE-1:0] i_rdi_pl_data;
  logic              i_fdi_lp_rx_rdy;
  logic              o_fdi_pl_valid;
  logic [D_SIZE-1:0] o_fdi_pl_data;
  logic              o_rx_overf_err;
  logic [P_SIZE:0]   o_rx_fifo_level;
`ifdef UCIE_CTL_RX_PARITY_EN
  logic              i_rdi_pl_parity;
  logic              o_rx_parity_err;
`endif

  modport master (
`ifdef UCIE_CTL_RX_PARITY_EN
    output i_rdi_pl_parity,
    input  o_rx_parity_err,
`endif
    output i_fdi_pl_state_sts,
    output i_rdi_pl_valid,
    output i_rdi_pl_data,
    output i_fdi_lp_rx_rdy,
    input  o_fdi_pl_valid,
    input  o_fdi_pl_data,
    input  o_rx_overf_err,
    input  o_rx_fifo_level
  );

  modport slave (
`ifdef UCIE_CTL_RX_PARITY_EN
    input  i_rdi_pl_parity,
    output o_rx_parity_err,
`endif
    input  i_fdi_pl_state_sts,
    input  i_rdi_pl_valid,
    input  i_rdi_pl_data,
    input  i_fdi_lp_rx_rdy,
    output o_fdi_pl_valid,
    output o_fdi_pl_data,
    output o_rx_overf_err,
    output o_rx_fifo_level
  );
endinterface

// File: rtl/ucie_ctl_rx_path.sv
// ucie_ctl_rx_path: UCIe receive datapath controller. RDI words are buffered in a
// synchronous FIFO and presented on FDI through a valid/ready output register.
// Traffic is gated on the FDI link state; leaving Active drains what is buffered.
// Optional macro UCIE_CTL_RX_PARITY_EN enables even-parity checking of RDI words.
module ucie_ctl_rx_path #(
  parameter logic [3:0] UCIE_ACTIVE = 4'd1,
  parameter int         FIFO_D_SIZE = 64,
  parameter int         FIFO_P_SIZE = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  ucie_ctl_rx_path_if.slave bus
);

  localparam int                 DEPTH     = 1 << FIFO_P_SIZE;
  localparam logic [FIFO_P_SIZE:0] DEPTH_CNT = (FIFO_P_SIZE+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_n;

  logic [FIFO_D_SIZE-1:0] mem [DEPTH];
  logic [FIFO_P_SIZE-1:0] wr_ptr_q;
  logic [FIFO_P_SIZE-1:0] rd_ptr_q;
  logic [FIFO_P_SIZE:0]   count_q;
  logic                   out_valid_q;
  logic [FIFO_D_SIZE-1:0] out_data_q;
  logic                   overf_q;

  logic link_active;
  logic fifo_empty;
  logic fifo_full;
  logic wr_allowed;
  logic rd_allowed;
  logic word_good;
  logic wr_attempt;
  logic wr_en;
  logic rd_en;
  logic overflow;
  logic out_accept;

  assign link_active = (bus.i_fdi_pl_state_sts == UCIE_ACTIVE);
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == DEPTH_CNT);

`ifdef UCIE_CTL_RX_PARITY_EN
  logic parity_q;
  logic parity_fail;

  // Even parity: the parity bit equals the XOR of all data bits.
  assign word_good   = ((^bus.i_rdi_pl_data) == bus.i_rdi_pl_parity);
  assign parity_fail = wr_attempt && !word_good;
`else
  assign word_good   = 1'b1;
`endif

  // Read/write qualification; a full FIFO still accepts a write when a read frees a slot.
  assign wr_attempt = wr_allowed && bus.i_rdi_pl_valid;
  assign out_accept = out_valid_q && bus.i_fdi_lp_rx_rdy;
  assign rd_en      = rd_allowed && !fifo_empty && (!out_valid_q || bus.i_fdi_lp_rx_rdy);
  assign wr_en      = wr_attempt && word_good && (!fifo_full || rd_en);
  assign overflow   = wr_attempt && word_good && fifo_full && !rd_en;

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  // Next-state logic; a word written in the last Active cycle still forces a drain.
  always_comb begin
    // NOTE: defaulting every comb output first keeps the block free of inferred latches.
    state_n = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (link_active) state_n = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!link_active) begin
          if (!fifo_empty || out_valid_q || wr_en) state_n = S_DRAIN;
          else                                     state_n = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (link_active)                      state_n = S_ACTIVE;
        else if (fifo_empty && !out_valid_q)  state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FSM outputs: which side of the FIFO is enabled in each state.
  always_comb begin
    wr_allowed = 1'b0;
    rd_allowed = 1'b0;
    unique case (state_q)
      S_ACTIVE: begin
        wr_allowed = 1'b1;
        rd_allowed = 1'b1;
      end
      S_DRAIN: rd_allowed = 1'b1;
      default: ;
    endcase
  end

  // FIFO storage; payload only, so it carries no reset.
  always_ff @(posedge i_clk) begin
    // NOTE: the memory array is deliberately not reset; pointers and count define validity.
    if (wr_en) mem[wr_ptr_q] <= bus.i_rdi_pl_data;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Output register: loads the FIFO head when free or being accepted, holds otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (rd_en) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mem[rd_ptr_q];
    end else if (out_accept) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sticky error flags; cleared whenever the FSM is heading into idle.
  always_ff @(posedge i_clk) begin
    if (i_rst)                  overf_q <= 1'b0;
    else if (state_n == S_IDLE) overf_q <= 1'b0;
    else if (overflow)          overf_q <= 1'b1;
  end

`ifdef UCIE_CTL_RX_PARITY_EN
  // Sticky parity error with the same clear rules as overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst)                  parity_q <= 1'b0;
    else if (state_n == S_IDLE) parity_q <= 1'b0;
    else if (parity_fail)       parity_q <= 1'b1;
  end

  assign bus.o_rx_parity_err = parity_q;
`endif

  assign bus.o_fdi_pl_valid  = out_valid_q;
  assign bus.o_fdi_pl_data   = out_data_q;
  assign bus.o_rx_overf_err  = overf_q;
  assign bus.o_rx_fifo_level = count_q;

endmodule
